// File: rtl/alu_packet_responder.sv
// Byte-stream packet responder: parses a 4-byte header, then echoes the payload
// or add-reduces it as little-endian 32-bit words and returns the 4-byte sum.
module alu_packet_responder #(
    parameter logic [7:0]  OP_ECHO   = 8'hEC,
    parameter logic [7:0]  OP_ADD    = 8'hA0,
    parameter int unsigned HDR_BYTES = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tvalid,
    output logic       s_axis_tready,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tvalid,
    input  logic       m_axis_tready,
    output logic       err_o
);

    typedef enum logic [2:0] {
        StOpcode, StRsvd, StLenL, StLenH, StEcho, StAddIn, StAddOut, StDrain
    } state_e;

    state_e      state_q;
    logic [7:0]  opcode_q;
    logic [7:0]  len_l_q;
    logic [15:0] cnt_q;
    logic [31:0] acc_q;
    logic [23:0] word_q;
    logic [7:0]  m_data_q;
    logic        m_valid_q;
    logic        err_q;
    logic        rdy_q;

    logic        s_fire;
    logic        m_fire;
    logic        m_free;
    logic [15:0] len_w;
    logic [15:0] pay_w;
    logic        len_short;
    logic [31:0] word_w;

    assign s_fire    = s_axis_tvalid && s_axis_tready;
    assign m_fire    = m_valid_q && m_axis_tready;
    assign m_free    = !m_valid_q || m_axis_tready;
    assign len_w     = {s_axis_tdata, len_l_q};
    assign len_short = len_w < 16'(HDR_BYTES);
    assign pay_w     = len_w - 16'(HDR_BYTES);
    assign word_w    = {s_axis_tdata, word_q};

    assign m_axis_tdata  = m_data_q;
    assign m_axis_tvalid = m_valid_q;
    assign err_o         = err_q;

    // rdy_q keeps the input closed during reset and for the first edge after it
    always_comb begin
        s_axis_tready = 1'b0;
        if (rdy_q) begin
            unique case (state_q)
                StEcho:   s_axis_tready = m_free;
                StAddOut: s_axis_tready = 1'b0;
                default:  s_axis_tready = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StOpcode;
            opcode_q  <= '0;
            len_l_q   <= '0;
            cnt_q     <= '0;
            acc_q     <= '0;
            word_q    <= '0;
            m_data_q  <= '0;
            m_valid_q <= 1'b0;
            err_q     <= 1'b0;
            rdy_q     <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
            err_q <= 1'b0;
            if (m_fire) m_valid_q <= 1'b0;

            case (state_q)
                StOpcode: if (s_fire) begin
                    opcode_q <= s_axis_tdata;
                    state_q  <= StRsvd;
                end
                StRsvd: if (s_fire) state_q <= StLenL;
                StLenL: if (s_fire) begin
                    len_l_q <= s_axis_tdata;
                    state_q <= StLenH;
                end
                StLenH: if (s_fire) begin
                    acc_q <= '0;
                    if (len_short) begin
                        err_q   <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= StOpcode;
                    end else begin
                        cnt_q <= pay_w;
                        if (opcode_q == OP_ECHO) begin
                            state_q <= (pay_w == '0) ? StOpcode : StEcho;
                        end else if (opcode_q == OP_ADD && pay_w != '0 && pay_w[1:0] == 2'b00) begin
                            state_q <= StAddIn;
                        end else begin
                            err_q   <= 1'b1;
                            state_q <= (pay_w == '0) ? StOpcode : StDrain;
                        end
                    end
                end
                StEcho: if (s_fire) begin
                    m_data_q  <= s_axis_tdata;
                    m_valid_q <= 1'b1;
                    cnt_q     <= cnt_q - 16'd1;
                    if (cnt_q == 16'd1) state_q <= StOpcode;
                end
                StAddIn: if (s_fire) begin
                    word_q <= word_w[31:8];
                    // remaining count ending in 01 means this byte completes a word
                    if (cnt_q[1:0] == 2'b01) acc_q <= acc_q + word_w;
                    cnt_q <= cnt_q - 16'd1;
                    if (cnt_q == 16'd1) state_q <= StAddOut;
                end
                StAddOut: begin
                    // cnt_q counts result bytes already loaded into the output register
                    if (cnt_q[2:0] == 3'd4) begin
                        if (m_fire) begin
                            cnt_q   <= '0;
                            state_q <= StOpcode;
                        end
                    end else if (m_free) begin
                        m_data_q  <= acc_q[{cnt_q[1:0], 3'b000} +: 8];
                        m_valid_q <= 1'b1;
                        cnt_q     <= cnt_q + 16'd1;
                    end
                end
                StDrain: if (s_fire) begin
                    cnt_q <= cnt_q - 16'd1;
                    if (cnt_q == 16'd1) state_q <= StOpcode;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_packet_responder.sv
// Directed bench for alu_packet_responder: echo, add-reduce, stalls, faults, reset.
`timescale 1ns/1ps
module tb_alu_packet_responder;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b1;
    logic [7:0] s_axis_tdata = 8'h00;
    logic       s_axis_tvalid = 1'b0;
    logic       s_axis_tready;
    logic [7:0] m_axis_tdata;
    logic       m_axis_tvalid;
    logic       m_axis_tready = 1'b1;
    logic       err_o;

    int n_checks = 0;
    int n_fail = 0;
    int err_cnt = 0;
    int stalls = 0;
    int rdy_mode = 0;
    int rdy_cyc = 0;
    logic [7:0] out_q[$];

    alu_packet_responder dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .err_o         (err_o)
    );

    initial forever #5 clk_i = ~clk_i;

    // Downstream ready: always, or one cycle in three
    initial forever begin
        @(posedge clk_i);
        #1;
        m_axis_tready = (rdy_mode == 0) || (rdy_cyc % 3 == 0);
        rdy_cyc++;
    end

    // Mid-cycle monitor: a handshake seen here completes on the next rising edge
    initial forever begin
        @(negedge clk_i);
        if (rst_ni && m_axis_tvalid && m_axis_tready) out_q.push_back(m_axis_tdata);
        if (rst_ni && err_o) err_cnt++;
    end

    task automatic send_byte(input logic [7:0] b);
        int waited = 0;
        s_axis_tdata  = b;
        s_axis_tvalid = 1'b1;
        @(negedge clk_i);
        while (!s_axis_tready && waited < 200) begin
            stalls++;
            waited++;
            @(negedge clk_i);
        end
        if (!s_axis_tready) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: byte %02h tready=%b, want 1", b, s_axis_tready);
        end
        @(posedge clk_i);
        #1;
        s_axis_tvalid = 1'b0;
    endtask

    task automatic send_seq(input logic [7:0] bytes[$]);
        foreach (bytes[i]) send_byte(bytes[i]);
    endtask

    task automatic wait_out(input int n);
        int k = 0;
        while (out_q.size() < n && k < 500) begin
            @(posedge clk_i);
            k++;
        end
        repeat (8) @(posedge clk_i);
        #1;
    endtask

    task automatic clear_obs();
        out_q.delete();
        err_cnt = 0;
        stalls  = 0;
    endtask

    task automatic test_reset();
        #2 rst_ni = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        n_checks++;
        if (s_axis_tready !== 1'b0) begin
            n_fail++; $display("FAIL rst_s_tready: got %b want 0", s_axis_tready);
        end
        n_checks++;
        if (m_axis_tvalid !== 1'b0) begin
            n_fail++; $display("FAIL rst_m_tvalid: got %b want 0", m_axis_tvalid);
        end
        n_checks++;
        if (m_axis_tdata !== 8'h00) begin
            n_fail++; $display("FAIL rst_m_tdata: got %02h want 00", m_axis_tdata);
        end
        n_checks++;
        if (err_o !== 1'b0) begin
            n_fail++; $display("FAIL rst_err: got %b want 0", err_o);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        n_checks++;
        if (s_axis_tready !== 1'b0) begin
            n_fail++; $display("FAIL rst_release_tready: got %b want 0 before edge", s_axis_tready);
        end
        @(posedge clk_i);
        #1;
        n_checks++;
        if (s_axis_tready !== 1'b1) begin
            n_fail++; $display("FAIL rst_first_edge_tready: got %b want 1", s_axis_tready);
        end
        clear_obs();
    endtask

    task automatic test_echo();
        logic [7:0] pkt[$];
        logic [7:0] exp[$];
        logic [7:0] got;
        clear_obs();
        pkt = '{8'hEC, 8'h00, 8'h08, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
        exp = '{8'h11, 8'h22, 8'h33, 8'h44};
        send_seq(pkt);
        wait_out(exp.size());
        n_checks++;
        if (out_q.size() != exp.size()) begin
            n_fail++; $display("FAIL echo_count: got %0d want %0d", out_q.size(), exp.size());
        end
        foreach (exp[i]) begin
            got = (i < out_q.size()) ? out_q[i] : 8'h00;
            n_checks++;
            if (got !== exp[i]) begin
                n_fail++; $display("FAIL echo_byte%0d: got %02h want %02h", i, got, exp[i]);
            end
        end
        n_checks++;
        if (err_cnt != 0) begin
            n_fail++; $display("FAIL echo_err: got %0d pulses want 0", err_cnt);
        end
    endtask

    task automatic test_add();
        logic [7:0] pkt[$];
        logic [7:0] exp[$];
        logic [7:0] got;
        clear_obs();
        pkt = '{8'hA0, 8'h00, 8'h0C, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF,
                8'h02, 8'h00, 8'h00, 8'h00};
        exp = '{8'h01, 8'h00, 8'h00, 8'h00};
        send_seq(pkt);
        wait_out(exp.size());
        n_checks++;
        if (out_q.size() != exp.size()) begin
            n_fail++; $display("FAIL add_wrap_count: got %0d want %0d", out_q.size(), exp.size());
        end
        foreach (exp[i]) begin
            got = (i < out_q.size()) ? out_q[i] : 8'h00;
            n_checks++;
            if (got !== exp[i]) begin
                n_fail++; $display("FAIL add_wrap_byte%0d: got %02h want %02h", i, got, exp[i]);
            end
        end
        n_checks++;
        if (err_cnt != 0) begin
            n_fail++; $display("FAIL add_err: got %0d pulses want 0", err_cnt);
        end
        // 0x04030201 + 0x40302010 = 0x44332211
        clear_obs();
        pkt = '{8'hA0, 8'h00, 8'h0C, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04,
                8'h10, 8'h20, 8'h30, 8'h40};
        exp = '{8'h11, 8'h22, 8'h33, 8'h44};
        send_seq(pkt);
        wait_out(exp.size());
        n_checks++;
        if (out_q.size() != exp.size()) begin
            n_fail++; $display("FAIL add_sum_count: got %0d want %0d", out_q.size(), exp.size());
        end
        foreach (exp[i]) begin
            got = (i < out_q.size()) ? out_q[i] : 8'h00;
            n_checks++;
            if (got !== exp[i]) begin
                n_fail++; $display("FAIL add_sum_byte%0d: got %02h want %02h", i, got, exp[i]);
            end
        end
    endtask

    task automatic test_stall();
        logic [7:0] pkt[$];
        logic [7:0] got;
        clear_obs();
        rdy_cyc  = 0;
        rdy_mode = 1;
        pkt = '{8'hEC, 8'h00, 8'h14, 8'h00};
        for (int i = 0; i < 16; i++) pkt.push_back(8'(i));
        send_seq(pkt);
        wait_out(16);
        rdy_mode = 0;
        n_checks++;
        if (out_q.size() != 16) begin
            n_fail++; $display("FAIL stall_count: got %0d want 16", out_q.size());
        end
        for (int i = 0; i < 16; i++) begin
            got = (i < out_q.size()) ? out_q[i] : 8'hFF;
            n_checks++;
            if (got !== 8'(i)) begin
                n_fail++; $display("FAIL stall_byte%0d: got %02h want %02h", i, got, 8'(i));
            end
        end
    endtask

    task automatic test_unknown_opcode();
        logic [7:0] pkt[$];
        clear_obs();
        pkt = '{8'h55, 8'h00, 8'h06, 8'h00, 8'hAA, 8'hBB,
                8'hEC, 8'h00, 8'h05, 8'h00, 8'h77};
        send_seq(pkt);
        wait_out(1);
        n_checks++;
        if (err_cnt != 1) begin
            n_fail++; $display("FAIL unk_err: got %0d pulse cycles want 1", err_cnt);
        end
        n_checks++;
        if (out_q.size() != 1) begin
            n_fail++; $display("FAIL unk_count: got %0d want 1", out_q.size());
        end
        n_checks++;
        if (out_q.size() > 0 && out_q[0] !== 8'h77) begin
            n_fail++; $display("FAIL unk_byte: got %02h want 77", out_q[0]);
        end
    endtask

    task automatic test_bad_length();
        logic [7:0] pkt[$];
        clear_obs();
        pkt = '{8'hEC, 8'h00, 8'h02, 8'h00};
        send_seq(pkt);
        wait_out(0);
        n_checks++;
        if (err_cnt != 1) begin
            n_fail++; $display("FAIL short_err: got %0d want 1", err_cnt);
        end
        n_checks++;
        if (out_q.size() != 0) begin
            n_fail++; $display("FAIL short_out: got %0d bytes want 0", out_q.size());
        end
        clear_obs();
        pkt = '{8'hA0, 8'h00, 8'h07, 8'h00, 8'h01, 8'h02, 8'h03};
        send_seq(pkt);
        wait_out(0);
        n_checks++;
        if (err_cnt != 1) begin
            n_fail++; $display("FAIL unaligned_err: got %0d want 1", err_cnt);
        end
        n_checks++;
        if (out_q.size() != 0) begin
            n_fail++; $display("FAIL unaligned_out: got %0d bytes want 0", out_q.size());
        end
        // Drain must end exactly after the payload
        clear_obs();
        pkt = '{8'hEC, 8'h00, 8'h05, 8'h00, 8'h5A};
        send_seq(pkt);
        wait_out(1);
        n_checks++;
        if (out_q.size() != 1 || out_q[0] !== 8'h5A) begin
            n_fail++; $display("FAIL after_drain: got %0d bytes first %02h want 1 byte 5A",
                               out_q.size(), (out_q.size() > 0) ? out_q[0] : 8'h00);
        end
        n_checks++;
        if (err_cnt != 0) begin
            n_fail++; $display("FAIL after_drain_err: got %0d want 0", err_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] pkt[$];
        logic [7:0] exp[$];
        logic [7:0] got;
        clear_obs();
        pkt = '{8'hEC, 8'h00, 8'h06, 8'h00, 8'h01, 8'h02,
                8'h55, 8'h00, 8'h05, 8'h00, 8'h99,
                8'hA0, 8'h00, 8'h08, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00};
        exp = '{8'h01, 8'h02, 8'h10, 8'h00, 8'h00, 8'h00};
        send_seq(pkt);
        n_checks++;
        if (stalls != 0) begin
            n_fail++; $display("FAIL b2b_stalls: got %0d idle cycles want 0", stalls);
        end
        wait_out(exp.size());
        n_checks++;
        if (out_q.size() != exp.size()) begin
            n_fail++; $display("FAIL b2b_count: got %0d want %0d", out_q.size(), exp.size());
        end
        foreach (exp[i]) begin
            got = (i < out_q.size()) ? out_q[i] : 8'hFF;
            n_checks++;
            if (got !== exp[i]) begin
                n_fail++; $display("FAIL b2b_byte%0d: got %02h want %02h", i, got, exp[i]);
            end
        end
        n_checks++;
        if (err_cnt != 1) begin
            n_fail++; $display("FAIL b2b_err: got %0d want 1", err_cnt);
        end
    endtask

    task automatic test_reset_mid_packet();
        logic [7:0] pkt[$];
        clear_obs();
        pkt = '{8'hEC, 8'h00, 8'h08, 8'h00, 8'hAA, 8'hBB};
        send_seq(pkt);
        rst_ni = 1'b0;
        #1;
        n_checks++;
        if (m_axis_tvalid !== 1'b0) begin
            n_fail++; $display("FAIL mid_rst_tvalid: got %b want 0", m_axis_tvalid);
        end
        n_checks++;
        if (s_axis_tready !== 1'b0) begin
            n_fail++; $display("FAIL mid_rst_tready: got %b want 0", s_axis_tready);
        end
        repeat (2) @(negedge clk_i);
        clear_obs();
        rst_ni = 1'b1;
        pkt = '{8'hEC, 8'h00, 8'h05, 8'h00, 8'h9C};
        send_seq(pkt);
        wait_out(1);
        n_checks++;
        if (out_q.size() != 1 || out_q[0] !== 8'h9C) begin
            n_fail++; $display("FAIL mid_rst_next: got %0d bytes first %02h want 1 byte 9C",
                               out_q.size(), (out_q.size() > 0) ? out_q[0] : 8'h00);
        end
        n_checks++;
        if (err_cnt != 0) begin
            n_fail++; $display("FAIL mid_rst_err: got %0d want 0", err_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_echo();
        test_add();
        test_stall();
        test_unknown_opcode();
        test_bad_length();
        test_back_to_back();
        test_reset_mid_packet();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
